// File: rtl/leg_uop_pkg.sv
// rtl/leg_uop_pkg.sv - shared uop word width and type for the decode/issue queue
package leg_uop_pkg;
    localparam int UOP_W = 64;
    typedef logic [UOP_W-1:0] uop_t;
endpackage

// File: rtl/uop_queue_mem.sv
// rtl/uop_queue_mem.sv - DEPTH x W register array, one write port, one async read port
module uop_queue_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Contents survive reset and flush; the pointers alone define occupancy.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/uop_queue.sv
// rtl/uop_queue.sv - circular uop FIFO between decode and uop_issue (optional UOP_QUEUE_BYPASS_EN)
module uop_queue
    import leg_uop_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int UOP_W = leg_uop_pkg::UOP_W,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [UOP_W-1:0] in_uop,
    input  logic             prev_valid,
    output logic             stalled,
    output logic [UOP_W-1:0] out_uop,
    output logic             valid,
    input  logic             next_stalled,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop, flush, empty;
    logic [UOP_W-1:0] rdata;

    assign flush   = reset || clear;
    assign empty   = (count_q == '0);
    assign stalled = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign pop     = !empty && !next_stalled;

`ifdef UOP_QUEUE_BYPASS_EN
    // An empty queue forwards decode straight to issue; only a stalled issue forces a write.
    assign valid   = empty ? prev_valid : 1'b1;
    assign out_uop = empty ? (prev_valid ? in_uop : '0) : rdata;
    assign push    = prev_valid && !stalled && !(empty && !next_stalled);
`else
    assign valid   = !empty;
    assign out_uop = valid ? rdata : '0;
    assign push    = prev_valid && !stalled;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    uop_queue_mem #(
        .DEPTH (DEPTH),
        .W     (UOP_W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (tail_q),
        .wdata (in_uop),
        .raddr (head_q),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_uop_queue.sv
// tb/tb_uop_queue.sv - directed self-checking bench for uop_queue at DEPTH=4
module tb_uop_queue;
    localparam int DEPTH = 4;
    localparam int UW    = 64;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [UW-1:0] in_uop = '0;
    logic          prev_valid = 1'b0;
    logic          stalled;
    logic [UW-1:0] out_uop;
    logic          valid;
    logic          next_stalled = 1'b0;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;
    logic [UW-1:0] exp_q [$];
    logic [UW-1:0] nxt;

    uop_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .in_uop       (in_uop),
        .prev_valid   (prev_valid),
        .stalled      (stalled),
        .out_uop      (out_uop),
        .valid        (valid),
        .next_stalled (next_stalled),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
        #1;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("reset_count", UW'(count), 0);
        chk("reset_valid", UW'(valid), 0);
        chk("reset_stalled", UW'(stalled), 0);
        chk("reset_out", out_uop, 0);

        // Fill A..D with issue stalled
        next_stalled = 1'b1;
        prev_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_uop = 64'hA0 + UW'(i);
            tick();
            chk("fill_count", UW'(count), UW'(i + 1));
            chk("fill_out", out_uop, 64'hA0);
            chk("fill_stalled", UW'(stalled), (i == 3) ? 1 : 0);
        end

        // Drain
        prev_valid = 1'b0;
        next_stalled = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_out", out_uop, 64'hA0 + UW'(i));
            chk("drain_valid", UW'(valid), 1);
            tick();
        end
        chk("drain_count", UW'(count), 0);
        chk("drain_valid_end", UW'(valid), 0);
        chk("drain_out_end", out_uop, 0);

        // Concurrent push and pop at count 2
        next_stalled = 1'b1;
        prev_valid = 1'b1;
        in_uop = 64'h100; tick();
        in_uop = 64'h101; tick();
        chk("conc_start_count", UW'(count), 2);
        next_stalled = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_uop = 64'h102 + UW'(i);
            chk("conc_out", out_uop, 64'h100 + UW'(i));
            chk("conc_stalled", UW'(stalled), 0);
            tick();
            chk("conc_count", UW'(count), 2);
        end
        prev_valid = 1'b0;
        chk("conc_tail0", out_uop, 64'h10A); tick();
        chk("conc_tail1", out_uop, 64'h10B); tick();
        chk("conc_empty", UW'(count), 0);

        // Wrap-around: 3 push then 3 pop, five rounds
        nxt = 64'h1000;
        for (int r = 0; r < 5; r++) begin
            next_stalled = 1'b1;
            prev_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                in_uop = nxt;
                exp_q.push_back(nxt);
                nxt = nxt + 1;
                tick();
            end
            prev_valid = 1'b0;
            next_stalled = 1'b0;
            chk("wrap_count", UW'(count), 3);
            for (int i = 0; i < 3; i++) begin
                chk("wrap_out", out_uop, exp_q.pop_front());
                tick();
            end
        end
        chk("wrap_empty", UW'(count), 0);

        // Full with simultaneous pop: push blocked for one cycle
        next_stalled = 1'b1;
        prev_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_uop = 64'h200 + UW'(i);
            tick();
        end
        in_uop = 64'h204;
        next_stalled = 1'b0;
        chk("fullpop_stalled", UW'(stalled), 1);
        chk("fullpop_out", out_uop, 64'h200);
        tick();
        chk("fullpop_count", UW'(count), 3);
        chk("fullpop_unstall", UW'(stalled), 0);
        next_stalled = 1'b1;
        tick();
        chk("fullpop_accept", UW'(count), 4);
        prev_valid = 1'b0;
        next_stalled = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("fullpop_drain", out_uop, 64'h200 + UW'(i));
            tick();
        end
        chk("fullpop_empty", UW'(count), 0);

        // Clear with a push in the same cycle
        next_stalled = 1'b1;
        prev_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_uop = 64'h300 + UW'(i);
            tick();
        end
        chk("clear_pre_count", UW'(count), 3);
        in_uop = 64'h303;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_count", UW'(count), 0);
        chk("clear_valid", UW'(valid), 0);
        chk("clear_stalled", UW'(stalled), 0);
        chk("clear_out", out_uop, 0);
        tick();
        chk("clear_held_count", UW'(count), 1);
        chk("clear_held_out", out_uop, 64'h303);
        prev_valid = 1'b0;
        next_stalled = 1'b0;
        tick();
        chk("clear_final", UW'(count), 0);

`ifdef UOP_QUEUE_BYPASS_EN
        prev_valid = 1'b1;
        in_uop = 64'h400;
        chk("bypass_valid", UW'(valid), 1);
        chk("bypass_out", out_uop, 64'h400);
        tick();
        prev_valid = 1'b0;
        chk("bypass_count", UW'(count), 0);
`else
        prev_valid = 1'b1;
        in_uop = 64'h400;
        chk("nobypass_valid", UW'(valid), 0);
        tick();
        prev_valid = 1'b0;
        chk("nobypass_count", UW'(count), 1);
        chk("nobypass_out", out_uop, 64'h400);
        tick();
        chk("nobypass_empty", UW'(count), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uop_queue.md
Name: uop_queue

Overview:
- Circular FIFO buffer between the decode stage and uop_issue.
- Absorbs decode bursts and issue-side stalls so decode is not throttled cycle-by-cycle.
- Upstream handshake: prev_valid / stalled. Downstream handshake: valid / next_stalled, the same pair uop_issue consumes.
- clear flushes all buffered uops on a pipeline redirect.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- UOP_W, 64, width of one uop word (defaults to the package constant).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush (redirect/mispredict); active-high.
- in_uop  input  UOP_W  uop from decode.
- prev_valid  input  1  in_uop is valid this cycle.
- stalled  output  1  backpressure to decode; asserted when the queue is full.
- out_uop  output  UOP_W  head uop toward uop_issue.
- valid  output  1  out_uop is valid.
- next_stalled  input  1  uop_issue cannot accept this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State:
  - mem[DEPTH] of UOP_W bits.
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- Output definitions:
  - push = prev_valid && !stalled
  - pop = valid && !next_stalled
- Combinational outputs:
  - stalled = (count == DEPTH), derived from registered count only. There is no combinational path from next_stalled to stalled.
  - valid = (count != 0).
  - out_uop = valid ? mem[head] : '0.
- Sequential update, in priority order:
  1. reset or clear: head = tail = count = 0. Any push or pop in that cycle is discarded. mem contents are not cleared.
  2. Push only: mem[tail] <= in_uop; tail++; count++.
  3. Pop only: head++; count--.
  4. Push and pop together: both pointers advance; count unchanged. This is legal at any occupancy 1..DEPTH-1.
- Full queue (count == DEPTH):
  - stalled = 1, so push is blocked even if a pop occurs that cycle.
  - stalled drops the cycle after the pop (one bubble accepted by design).
- Empty queue (count == 0):
  - valid = 0; pop is impossible; next_stalled is ignored.
- Latency: a uop pushed in cycle N appears on out_uop with valid = 1 in cycle N+1 at the earliest.
- Ordering: strict FIFO; no reordering and no dropping except on clear or reset.
- Reset values: stalled = 0, valid = 0, out_uop = 0, count = 0.
- Reset or clear mid-burst: the next cycle shows an empty queue. A prev_valid held high through the clear cycle is not captured in that cycle; it is accepted in the following cycle if still asserted.
- in_uop is ignored whenever push = 0.

Optional Feature:
- Macro: UOP_QUEUE_BYPASS_EN.
- Defined:
  - When count == 0, valid = prev_valid and out_uop = in_uop combinationally.
  - If next_stalled = 0 in that cycle, the uop passes through with zero latency and is not written; pointers and count are unchanged.
  - If next_stalled = 1, the uop is written normally.
  - stalled is unchanged by bypass.
- Undefined: no bypass; minimum latency is 1 cycle, as in Behaviour.

Decomposition:
- Package leg_uop_pkg holds:
  - localparam UOP_W = 64.
  - typedef logic [UOP_W-1:0] uop_t, used for in_uop and out_uop.
- One sub-module, uop_queue_mem: the DEPTH x UOP_W register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Pointer, count and handshake logic stay in uop_queue.

Test Plan (DEPTH = 4):
- Fill: push A, B, C, D on consecutive cycles with next_stalled = 1 -> count = 1, 2, 3, 4; stalled = 1 the cycle after D; out_uop = A throughout.
- Drain: from full, next_stalled = 0 for 4 cycles with prev_valid = 0 -> out_uop = A, B, C, D in order; then valid = 0, out_uop = 0, count = 0.
- Concurrent: count = 2, prev_valid = 1, next_stalled = 0 for 10 cycles -> count stays 2; output order equals input order; no stall.
- Wrap-around: 3 push + 3 pop, repeated 5 times (pointers wrap) -> every uop is emitted exactly once, in order.
- Full with pop: count = 4, prev_valid = 1, next_stalled = 0 -> the push is not accepted that cycle; count = 3 next cycle; the push is accepted the following cycle.
- Clear: count = 3, clear = 1 together with prev_valid = 1 -> the next cycle has count = 0, valid = 0, stalled = 0, and the incoming uop is not stored.
- Bypass (with UOP_QUEUE_BYPASS_EN): empty queue, prev_valid = 1, next_stalled = 0 -> valid = 1 and out_uop = in_uop in the same cycle; count remains 0.
